// File: rtl/usr_pkg.sv
// Shared mode encodings, FSM states and small helpers for the universal shift register.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASHR  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } usr_state_t;

  // Only single-bit movement ops are meaningful to repeat in a burst.
  function automatic logic is_shift_op(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
           (m == MODE_ROTR) || (m == MODE_ASHR);
  endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-value function for the register; shared by single-step and burst paths.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] po,
  input  logic [2:0]   op,
  input  logic [N-1:0] pi,
  input  logic         sin_l,
  input  logic         sin_r,
  output logic [N-1:0] nxt
);

  // Select the next register value; shifted-out bits are simply dropped.
  always_comb begin
    nxt = po;
    unique case (op)
      MODE_HOLD:  nxt = po;
      MODE_LOAD:  nxt = pi;
      MODE_SHL:   nxt = {po[N-2:0], sin_l};
      MODE_SHR:   nxt = {sin_r, po[N-1:1]};
      MODE_ROTL:  nxt = {po[N-2:0], po[N-1]};
      MODE_ROTR:  nxt = {po[0], po[N-1:1]};
      MODE_ASHR:  nxt = {po[N-1], po[N-1:1]};
      MODE_CLEAR: nxt = '0;
      default:    nxt = po;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and an auto-sequenced burst (busy/done).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  pi,
  input  logic          sin_l,
  input  logic          sin_r,
  input  logic          start,
  input  logic [CW-1:0] shamt,
  output logic [N-1:0]  po,
  output logic          sout_l,
  output logic          sout_r,
  output logic          busy,
  output logic          done
);

  usr_state_t    state, state_nxt;
  logic [2:0]    op, op_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  po_nxt, shift_nxt;
  logic          busy_nxt, done_nxt;
  logic [2:0]    unit_op;
  logic [CW-1:0] shamt_clamped;

  assign shamt_clamped = (shamt > CW'(N)) ? CW'(N) : shamt;

  // In a burst the latched op drives the shifter; otherwise the live mode does.
  assign unit_op = (state == ST_BURST) ? op : mode;

  usr_shift_unit #(.N(N)) u_shift (
    .po    (po),
    .op    (unit_op),
    .pi    (pi),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .nxt   (shift_nxt)
  );

  // Next-state / next-output logic; done defaults low so it is a single-cycle pulse.
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = cnt;
    po_nxt    = po;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    if (en) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            // Start edge only latches the request; po is left untouched.
            op_nxt  = mode;
            cnt_nxt = shamt_clamped;
            if ((shamt_clamped == '0) || !is_shift_op(mode)) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = ST_BURST;
              busy_nxt  = 1'b1;
            end
          end else begin
            po_nxt = shift_nxt;
          end
        end
        ST_BURST: begin
          // mode and start are ignored here; a start while busy is dropped.
          po_nxt  = shift_nxt;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register; reset wins over everything and aborts a burst without done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op    <= MODE_HOLD;
      cnt   <= '0;
      po    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      cnt   <= cnt_nxt;
      po    <= po_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  assign sout_l = po[N-1];
  assign sout_r = po[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed, table-driven bench for univ_shift_reg at N=8.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset, en, sin_l, sin_r, start;
  logic [2:0]    mode;
  logic [N-1:0]  pi;
  logic [CW-1:0] shamt;
  logic [N-1:0]  po;
  logic          sout_l, sout_r, busy, done;

  int n_pass = 0;
  int n_total = 0;

  univ_shift_reg #(.N(N), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .pi     (pi),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .shamt  (shamt),
    .po     (po),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock edge, then settle; also guards the busy/done exclusivity.
  task automatic step();
    @(posedge clk);
    #1;
    chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
  endtask

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] pi;
    logic       sl;
    logic       sr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[20];
  logic [7:0] sbits;
  logic [7:0] prior;

  initial begin
    // single-step vectors, expected values worked by hand
    vecs[0]  = '{1'b1, MODE_HOLD,  8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, MODE_HOLD,  8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, MODE_HOLD,  8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, MODE_LOAD,  8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[4]  = '{1'b1, MODE_SHL,   8'h00, 1'b1, 1'b0, 8'h4B};
    vecs[5]  = '{1'b1, MODE_LOAD,  8'h96, 1'b0, 1'b0, 8'h96};
    vecs[6]  = '{1'b1, MODE_ROTR,  8'h00, 1'b1, 1'b1, 8'h4B};
    vecs[7]  = '{1'b1, MODE_LOAD,  8'h96, 1'b0, 1'b0, 8'h96};
    vecs[8]  = '{1'b1, MODE_ASHR,  8'h00, 1'b0, 1'b0, 8'hCB};
    vecs[9]  = '{1'b1, MODE_LOAD,  8'h96, 1'b0, 1'b0, 8'h96};
    vecs[10] = '{1'b1, MODE_SHR,   8'h00, 1'b0, 1'b0, 8'h4B};
    vecs[11] = '{1'b1, MODE_CLEAR, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[12] = '{1'b1, MODE_LOAD,  8'h81, 1'b0, 1'b0, 8'h81};
    vecs[13] = '{1'b1, MODE_ROTL,  8'h00, 1'b0, 1'b0, 8'h03};
    vecs[14] = '{1'b1, MODE_ROTR,  8'h00, 1'b0, 1'b0, 8'h81};
    vecs[15] = '{1'b1, MODE_SHL,   8'h00, 1'b0, 1'b1, 8'h02};
    vecs[16] = '{1'b1, MODE_SHR,   8'h00, 1'b0, 1'b1, 8'h81};
    vecs[17] = '{1'b1, MODE_ASHR,  8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[18] = '{1'b0, MODE_CLEAR, 8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[19] = '{1'b0, MODE_LOAD,  8'h11, 1'b0, 1'b0, 8'hC0};

    // reset has priority over en/start/mode
    reset = 1'b1; en = 1'b1; mode = MODE_LOAD; pi = 8'hFF;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b1; shamt = 4'd3;
    step(); step();
    reset = 1'b0; start = 1'b0; mode = MODE_HOLD;
    chk("rst_po", {24'b0, po}, 32'h00);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);

    // table-driven single-step ops
    for (int i = 0; i < 20; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; pi = vecs[i].pi;
      sin_l = vecs[i].sl; sin_r = vecs[i].sr;
      step();
      chk($sformatf("vec%0d_po", i), {24'b0, po}, {24'b0, vecs[i].exp});
      chk($sformatf("vec%0d_sout_l", i), {31'b0, sout_l}, {31'b0, vecs[i].exp[7]});
      chk($sformatf("vec%0d_sout_r", i), {31'b0, sout_r}, {31'b0, vecs[i].exp[0]});
    end
    en = 1'b1; sin_l = 1'b0; sin_r = 1'b0;

    // rotl burst of 3 with a start pulse mid-burst
    mode = MODE_LOAD; pi = 8'h3C; step();
    mode = MODE_ROTL; shamt = 4'd3; start = 1'b1; step();
    start = 1'b0; mode = MODE_HOLD;
    chk("b3_start_po", {24'b0, po}, 32'h3C);
    chk("b3_start_busy", {31'b0, busy}, 32'd1);
    step();
    chk("b3_s1_po", {24'b0, po}, 32'h78);
    start = 1'b1; mode = MODE_LOAD; pi = 8'h00;
    step();
    start = 1'b0; mode = MODE_HOLD;
    chk("b3_s2_po", {24'b0, po}, 32'hF0);
    chk("b3_s2_busy", {31'b0, busy}, 32'd1);
    step();
    chk("b3_end_po", {24'b0, po}, 32'hE1);
    chk("b3_end_done", {31'b0, done}, 32'd1);
    chk("b3_end_busy", {31'b0, busy}, 32'd0);
    step();
    chk("b3_after_done", {31'b0, done}, 32'd0);
    chk("b3_after_po", {24'b0, po}, 32'hE1);

    // rotl burst of 4 with en dropped for 2 cycles after the 2nd shift
    mode = MODE_LOAD; pi = 8'h3C; step();
    mode = MODE_ROTL; shamt = 4'd4; start = 1'b1; step();
    start = 1'b0; mode = MODE_HOLD;
    step(); step();
    chk("b4_s2_po", {24'b0, po}, 32'hF0);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("b4_stall%0d_po", i), {24'b0, po}, 32'hF0);
      chk($sformatf("b4_stall%0d_busy", i), {31'b0, busy}, 32'd1);
      chk($sformatf("b4_stall%0d_done", i), {31'b0, done}, 32'd0);
    end
    en = 1'b1;
    step();
    chk("b4_s3_po", {24'b0, po}, 32'hE1);
    chk("b4_s3_done", {31'b0, done}, 32'd0);
    step();
    chk("b4_end_po", {24'b0, po}, 32'hC3);
    chk("b4_end_done", {31'b0, done}, 32'd1);
    step();
    chk("b4_after_done", {31'b0, done}, 32'd0);

    // shr burst of 8 aborted by reset after 3 shifts
    mode = MODE_LOAD; pi = 8'h3C; step();
    mode = MODE_SHR; shamt = 4'd8; start = 1'b1; step();
    start = 1'b0; mode = MODE_HOLD;
    step(); step(); step();
    chk("b5_s3_po", {24'b0, po}, 32'h07);
    reset = 1'b1; step(); reset = 1'b0;
    chk("b5_rst_po", {24'b0, po}, 32'h00);
    chk("b5_rst_busy", {31'b0, busy}, 32'd0);
    chk("b5_rst_done", {31'b0, done}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("b5_nodone%0d", i), {31'b0, done}, 32'd0);
    end
    chk("b5_idle_po", {24'b0, po}, 32'h00);

    // shamt=0 completes immediately with po unchanged
    mode = MODE_LOAD; pi = 8'h3C; step();
    mode = MODE_SHL; shamt = 4'd0; start = 1'b1; step();
    start = 1'b0; mode = MODE_HOLD;
    chk("z_done", {31'b0, done}, 32'd1);
    chk("z_busy", {31'b0, busy}, 32'd0);
    chk("z_po", {24'b0, po}, 32'h3C);
    step();
    chk("z_done_clr", {31'b0, done}, 32'd0);

    // start with a non-shift mode completes immediately, po unchanged
    mode = MODE_LOAD; pi = 8'hFF; shamt = 4'd5; start = 1'b1; step();
    start = 1'b0; mode = MODE_HOLD;
    chk("ld_done", {31'b0, done}, 32'd1);
    chk("ld_po", {24'b0, po}, 32'h3C);
    step();
    chk("ld_done_clr", {31'b0, done}, 32'd0);

    // shamt=15 clamps to 8: full rotation returns to 3C
    mode = MODE_ROTL; shamt = 4'd15; start = 1'b1; step();
    start = 1'b0; mode = MODE_HOLD;
    for (int i = 0; i < 7; i++) step();
    chk("clamp_s7_busy", {31'b0, busy}, 32'd1);
    chk("clamp_s7_po", {24'b0, po}, 32'h1E);
    step();
    chk("clamp_end_po", {24'b0, po}, 32'h3C);
    chk("clamp_end_done", {31'b0, done}, 32'd1);
    step();
    chk("clamp_after_busy", {31'b0, busy}, 32'd0);

    // serial-in shl burst of 8, sout_l streams the prior word MSB first
    prior = 8'h5A;
    sbits = 8'b0100_1101;
    mode = MODE_LOAD; pi = prior; step();
    mode = MODE_SHL; shamt = 4'd8; start = 1'b1; step();
    start = 1'b0; mode = MODE_HOLD;
    for (int k = 0; k < 8; k++) begin
      sin_l = sbits[k];
      chk($sformatf("ser_sout_l%0d", k), {31'b0, sout_l}, {31'b0, prior[7-k]});
      step();
    end
    sin_l = 1'b0;
    chk("ser_po", {24'b0, po}, 32'hB2);
    chk("ser_done", {31'b0, done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
